// File: rtl/depacketizer_n_sub_if.sv
// Flit-side and consumer-side signals of the multi-flit depacketizer.
// The slave modport is the depacketizer; the master modport is its environment.
interface depacketizer_n_sub_if #(
    parameter int WIDTH_FLIT       = 36,
    parameter int NUM_FLITS        = 4,
    parameter int VC_ADDRESS_WIDTH = 2,
    parameter int WIDTH_DATA       = 120
);
    localparam int NFLITS_W = $clog2(NUM_FLITS + 1);

    logic [WIDTH_FLIT-1:0]       flit_in;
    logic                        valid_in;
    logic                        ready_out;
    logic [WIDTH_DATA-1:0]       data_out;
    logic [VC_ADDRESS_WIDTH-1:0] vc_out;
    logic [NFLITS_W-1:0]         nflits_out;
    logic                        valid_out;
    logic                        ready_in;
    logic                        err_out;

    modport master (
        output flit_in, valid_in, ready_in,
        input  ready_out, data_out, vc_out, nflits_out, valid_out, err_out
    );

    modport slave (
        input  flit_in, valid_in, ready_in,
        output ready_out, data_out, vc_out, nflits_out, valid_out, err_out
    );
endinterface

// File: rtl/depacketizer_n_sub.sv
// Reassembles 1..NUM_FLITS NoC flits into one word with a registered valid/ready output.
// Optional error counter enabled by defining DEPKT_ERR_CNT_EN.
module depacketizer_n_sub #(
    parameter int WIDTH_FLIT       = 36,
    parameter int NUM_FLITS        = 4,
    parameter int VC_ADDRESS_WIDTH = 2,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int WIDTH_DATA       = 120
) (
    input  logic clk,
    input  logic rst,
`ifdef DEPKT_ERR_CNT_EN
    input  logic        err_cnt_clr,
    output logic [15:0] err_cnt_out,
`endif
    depacketizer_n_sub_if.slave bus
);
    localparam int WIDTH_BODY     = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
    localparam int WIDTH_HEAD     = WIDTH_BODY - ADDRESS_WIDTH;
    localparam int WIDTH_DATA_IDL = NUM_FLITS * WIDTH_BODY - ADDRESS_WIDTH;
    localparam int CNT_W          = $clog2(NUM_FLITS + 1);

    if (WIDTH_DATA > WIDTH_DATA_IDL) begin : g_width_check
        $error("WIDTH_DATA exceeds NUM_FLITS*WIDTH_BODY-ADDRESS_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                      state_q, state_d;
    logic [WIDTH_DATA_IDL-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
    logic                        err_q, err_d;

    logic                        f_head, f_tail, accept;
    logic [VC_ADDRESS_WIDTH-1:0] f_vc;
    logic [WIDTH_DATA_IDL-1:0]   head_acc, body_acc;

    assign f_head = bus.flit_in[WIDTH_FLIT-2];
    assign f_tail = bus.flit_in[WIDTH_FLIT-3];
    assign f_vc   = bus.flit_in[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];

    assign bus.ready_out = (state_q != HOLD) | bus.ready_in;
    assign accept        = bus.valid_in & bus.flit_in[WIDTH_FLIT-1] & bus.ready_out;

    always_comb begin
        head_acc = '0;
        head_acc[WIDTH_DATA_IDL-1 -: WIDTH_HEAD] = bus.flit_in[WIDTH_HEAD-1:0];
        // cnt_q flits are already stored, so the next field lands in slot cnt_q
        body_acc = acc_q;
        for (int k = 1; k < NUM_FLITS; k++) begin
            if (cnt_q == CNT_W'(k))
                body_acc[WIDTH_DATA_IDL-1-WIDTH_HEAD-(k-1)*WIDTH_BODY -: WIDTH_BODY] =
                    bus.flit_in[WIDTH_BODY-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        vc_d    = vc_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && !f_head) err_d = 1'b1;
            end
            ACCUM: begin
                if (accept && !f_head) begin
                    acc_d = body_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (f_tail) begin
                        state_d = HOLD;
                    end else if (cnt_q == CNT_W'(NUM_FLITS - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (bus.ready_in) begin
                    state_d = IDLE;
                    if (accept && !f_head) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A head flit always starts a fresh packet; inside ACCUM it aborts the old one
        if (accept && f_head) begin
            if (state_q == ACCUM) err_d = 1'b1;
            acc_d = head_acc;
            cnt_d = CNT_W'(1);
            vc_d  = f_vc;
            if (f_tail) begin
                state_d = HOLD;
            end else if (NUM_FLITS == 1) begin
                err_d   = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
        end
    end

    assign bus.valid_out  = (state_q == HOLD);
    assign bus.data_out   = acc_q[WIDTH_DATA_IDL-1 -: WIDTH_DATA];
    assign bus.vc_out     = vc_q;
    assign bus.nflits_out = cnt_q;
    assign bus.err_out    = err_q;

`ifdef DEPKT_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_cnt_clr) begin
            err_cnt_q <= '0;
        end else if (err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_out = err_cnt_q;
`endif
endmodule

// File: doc/depacketizer_n_sub.md
Name: depacketizer_n_sub

Overview:
- Multi-flit successor of the single-flit depacketizer.
- Accepts NoC flits one per cycle from a router output port and strips the per-flit control fields (valid, head, tail, VC id, and the destination address on the head flit).
- Reassembles the data fields of 1..NUM_FLITS flits into one data word.
- Presents the word to the module-side consumer over a registered valid/ready interface.
- Sits between a NoC fabric port and a translator/module input.

Parameters:
- WIDTH_FLIT, 36, flit width in bits.
- NUM_FLITS, 4, maximum flits per packet (≥1).
- VC_ADDRESS_WIDTH, 2, VC id field width.
- ADDRESS_WIDTH, 4, destination address field width (head flit only).
- WIDTH_DATA, 120, output data width. Must be ≤ WIDTH_DATA_IDL, checked by an elaboration assertion.
- Derived: WIDTH_BODY = WIDTH_FLIT-3-VC_ADDRESS_WIDTH.
- Derived: WIDTH_HEAD = WIDTH_BODY-ADDRESS_WIDTH.
- Derived: WIDTH_DATA_IDL = NUM_FLITS*WIDTH_BODY-ADDRESS_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous assert, active-high.
- flit_in  in  WIDTH_FLIT  flit, MSB-first fields: [valid][head][tail][vc][addr (head flit only)][data].
- valid_in  in  1  flit strobe. A flit is accepted only when valid_in & flit_in[WIDTH_FLIT-1] & ready_out.
- ready_out  out  1  backpressure to the NoC.
- data_out  out  WIDTH_DATA  reassembled data.
- vc_out  out  VC_ADDRESS_WIDTH  VC id of the packet's head flit.
- nflits_out  out  clog2(NUM_FLITS+1)  number of flits in the delivered packet.
- valid_out  out  1  output word valid.
- ready_in  in  1  consumer ready.
- err_out  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset values: valid_out=0, err_out=0, data_out=0, vc_out=0, nflits_out=0, state=IDLE, accumulator=0, flit count=0.
- Reset asserted mid-packet discards the partial packet.
- Assembly: the head flit's data field (WIDTH_HEAD bits) occupies the MSBs of a WIDTH_DATA_IDL accumulator. Each subsequent body/tail data field (WIDTH_BODY bits) follows immediately below the previous one.
- Unfilled LSBs of a short packet are zero.
- data_out = accumulator[WIDTH_DATA_IDL-1 -: WIDTH_DATA].
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - Accepted head+tail flit → load as a single-flit packet, go to HOLD.
  - Accepted head flit without tail → go to ACCUM, count=1, latch vc.
  - Accepted non-head flit → drop it, pulse err_out, stay in IDLE.
- ACCUM:
  - Accepted non-head flit → append its data, count+1. With tail → HOLD.
  - If count reaches NUM_FLITS without a tail → pulse err_out, discard the packet, go to IDLE; remaining flits up to the tail are then dropped as non-head flits.
  - Accepted head flit → pulse err_out, discard the partial packet, restart ACCUM with the new head. A head+tail flit goes to HOLD.
  - A flit whose vc differs from the latched vc is still appended. Interleaving is not supported; the VC is tracked for reporting only.
- HOLD:
  - valid_out=1; data_out, vc_out and nflits_out are stable.
  - On valid_out & ready_in → leave HOLD.
  - If a head flit is accepted in the same cycle, go to ACCUM (or HOLD if it is head+tail) with the new packet. Otherwise go to IDLE.
- ready_out = 1 in IDLE/ACCUM; ready_out = ready_in in HOLD.
- Flits are never lost while ready_out=1.
- Latency: valid_out rises the cycle after the tail is accepted. Back-to-back single-flit packets sustain 1 packet/cycle while ready_in=1.
- err_out is registered and high for exactly one cycle per error event.

Optional Feature:
- Macro: DEPKT_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt_out, 16 bits.
  - Increments on every err_out pulse and saturates at 16'hFFFF.
  - Reset to 0.
  - Adds input err_cnt_clr, 1 bit, synchronous clear. Clear takes priority over a simultaneous increment.
- Undefined: no such ports or logic; err_out is unchanged.

Test Plan:
- Defaults (WIDTH_FLIT=36, NUM_FLITS=4, WIDTH_DATA=120): 4-flit packet, vc=2, head data 27'h1234567, body/tail data 0x7FFFFFF/0x0/0x5555555, ready_in=1 → valid_out one cycle after the tail. data_out = top 120 bits of {27'h1234567, 31'h7FFFFFF, 31'h0, 31'h5555555}, vc_out=2, nflits_out=4, err_out=0.
- 2-flit packet (head+tail) → nflits_out=2, lower 62 accumulator bits zero.
- Hold ready_in=0 for 5 cycles after tail → ready_out=0, outputs stable. Release with a head+tail flit pending → the first word completes, the new word appears the next cycle, no flit dropped.
- Body flit while IDLE → dropped, err_out pulses once. Head, body, then head+tail → err_out pulses once, output equals the second packet only, nflits_out=1.
- 5 flits with no tail (head + 4 bodies) → err_out at the 4th flit, no valid_out; the 5th flit dropped with a second err pulse. With DEPKT_ERR_CNT_EN, err_cnt_out=2; err_cnt_clr → 0.
- Assert rst while in ACCUM after 2 flits → next cycle state IDLE, valid_out=0. A fresh 1-flit packet then delivers correctly.
